// File: rtl/ser_collector_pkg.sv
// ser_collector_pkg
// Shared definitions for the serial-to-parallel collector: the FSM state
// encoding and the default word width / gap tolerance used by ser_collector
// and its testbench.
package ser_collector_pkg;

  // Default number of serial bits assembled into one parallel word.
  localparam int WIDTH_DEFAULT   = 8;

  // Default number of consecutive invalid cycles tolerated mid-word.
  localparam int GAP_MAX_DEFAULT = 3;

  // IDLE: no partial word held. COLLECT: at least one bit of a word taken.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/ser_collector.sv
// ser_collector
// Collects a qualified serial bit stream (LSB first) into WIDTH-bit parallel
// words. A word that stalls for GAP_MAX consecutive invalid cycles is thrown
// away and flagged.
//
// Ports:
//   CLK        in   single clock, rising edge
//   RST        in   synchronous active-high reset
//   Serial_In  in   serial data bit, LSB first
//   Valid_In   in   qualifier for Serial_In
//   P_DATA     out  last completed word (WIDTH bits), changes only on completion
//   Data_Valid out  one-cycle pulse: P_DATA just loaded with a new word
//   Frame_Err  out  one-cycle pulse: partial word aborted on gap timeout
//   Busy       out  high while a word is partially collected
module ser_collector
  import ser_collector_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int GAP_MAX = GAP_MAX_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Serial_In,
  input  logic             Valid_In,
  output logic [WIDTH-1:0] P_DATA,
  output logic             Data_Valid,
  output logic             Frame_Err,
  output logic             Busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP_MAX + 1);

  // Bit count at which the next accepted bit completes the word, and the gap
  // count at which the next invalid cycle aborts it.
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP_MAX - 1);

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [WIDTH-1:0] shreg;

  // Bits shift in from the top, so after WIDTH shifts the first bit sits at
  // position 0. The final bit is merged straight into P_DATA rather than
  // shifted, which keeps the completion latency at one cycle. Stale bits from
  // an earlier word are always shifted out before they could reach P_DATA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (Valid_In) begin
            shreg   <= {Serial_In, shreg[WIDTH-1:1]};
            bit_cnt <= BW'(1);
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (Valid_In) begin
            gap_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              P_DATA     <= {Serial_In, shreg[WIDTH-1:1]};
              Data_Valid <= 1'b1;
              bit_cnt    <= '0;
              state      <= IDLE;
            end else begin
              shreg   <= {Serial_In, shreg[WIDTH-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (gap_cnt == LAST_GAP) begin
            // Gap has reached GAP_MAX: drop the partial word, keep P_DATA.
            Frame_Err <= 1'b1;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  assign Busy = (state == COLLECT);

endmodule

// File: tb/tb_ser_collector.sv
// tb_ser_collector
// Self-checking bench for ser_collector (WIDTH=8, GAP_MAX=3). A queue-based
// reference model tracks accepted bits and the running gap; completed or
// aborted words are pushed to a scoreboard that a negedge monitor drains.
module tb_ser_collector;
  import ser_collector_pkg::*;

  localparam int W = 8;
  localparam int G = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         frame_err;
  logic         busy;

  always #5 clk = ~clk;

  ser_collector #(.WIDTH(W), .GAP_MAX(G)) dut (
    .CLK        (clk),
    .RST        (rst),
    .Serial_In  (serial_in),
    .Valid_In   (valid_in),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .Frame_Err  (frame_err),
    .Busy       (busy)
  );

  typedef struct {
    bit           is_frame_err;
    logic [W-1:0] word;
  } event_t;

  event_t       exp_q[$];
  bit           model_bits[$];
  int           model_gap = 0;
  logic [W-1:0] model_pdata = '0;
  bit           model_dv = 1'b0;
  bit           model_fe = 1'b0;
  bit           mon_en = 1'b0;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference behaviour for one rising edge, expressed as a list of bits
  // gathered so far plus a count of invalid cycles since the last bit.
  function automatic void modelStep(input bit r, input bit v, input bit b);
    logic [W-1:0] w;
    event_t e;
    model_dv = 1'b0;
    model_fe = 1'b0;
    if (r) begin
      model_bits.delete();
      model_gap   = 0;
      model_pdata = '0;
      return;
    end
    if (v) begin
      model_bits.push_back(b);
      model_gap = 0;
      if (model_bits.size() == W) begin
        for (int i = 0; i < W; i++) w[i] = model_bits[i];
        model_pdata    = w;
        model_dv       = 1'b1;
        e.is_frame_err = 1'b0;
        e.word         = w;
        exp_q.push_back(e);
        model_bits.delete();
      end
    end else if (model_bits.size() > 0) begin
      model_gap++;
      if (model_gap == G) begin
        model_fe       = 1'b1;
        e.is_frame_err = 1'b1;
        e.word         = model_pdata;
        exp_q.push_back(e);
        model_bits.delete();
        model_gap = 0;
      end
    end
  endfunction

  // Drive one cycle of inputs away from the edge, then advance the model.
  task automatic applyStimulus(input bit r, input bit v, input bit b);
    #1;
    rst       = r;
    valid_in  = v;
    serial_in = b;
    @(posedge clk);
    modelStep(r, v, b);
  endtask

  task automatic sendWord(input logic [W-1:0] w, input int gap);
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b0, 1'b1, w[i]);
      if (i < W - 1) repeat (gap) applyStimulus(1'b0, 1'b0, 1'($urandom % 2));
    end
  endtask

  // Monitor: cycle-exact flag and data checks plus scoreboard draining.
  always @(negedge clk) begin
    if (mon_en) begin
      event_t e;
      checkOutput("busy", busy, model_bits.size() > 0);
      checkOutput("data_valid", data_valid, model_dv);
      checkOutput("frame_err", frame_err, model_fe);
      checkOutput("p_data", p_data, model_pdata);
      checkOutput("flag_overlap", data_valid & frame_err, 1'b0);
      if (data_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL sb_unexpected: got dv=%0b fe=%0b required no event at %0t",
                   data_valid, frame_err, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_kind", frame_err, e.is_frame_err);
          checkOutput("sb_word", p_data, e.word);
        end
      end
    end
  end

  initial begin
    // Reset with random inputs.
    applyStimulus(1'b1, 1'($urandom % 2), 1'($urandom % 2));
    mon_en = 1'b1;
    applyStimulus(1'b1, 1'($urandom % 2), 1'($urandom % 2));
    #2;
    checkOutput("reset_p_data", p_data, 0);
    checkOutput("reset_flags", {busy, data_valid, frame_err}, 0);

    // Continuous word, spaced word, aborted partial, recovery word.
    sendWord(8'hA5, 0);
    sendWord(8'h3C, 2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'($urandom % 2));
    repeat (3) applyStimulus(1'b0, 1'b0, 1'($urandom % 2));
    sendWord(8'h01, 0);

    // Back-to-back words.
    sendWord(8'hFF, 0);
    sendWord(8'h00, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset mid-word, then a clean word.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'($urandom % 2));
    applyStimulus(1'b1, 1'b1, 1'($urandom % 2));
    sendWord(8'h96, 0);

    // Randomized traffic with occasional resets and long gaps.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 250) == 0, ($urandom % 3) != 0, 1'($urandom % 2));
    end

    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ser_collector.md
SER_COLLECTOR -- requirements
Module: ser_collector

Interface
REQ-001 Parameter WIDTH, default 8: number of serial bits per parallel word, legal range 2..32.
REQ-002 Parameter GAP_MAX, default 3: consecutive invalid cycles tolerated mid-word before abort, legal range 1..15.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 Serial_In  input  1  serial data bit, LSB first, from upstream lfsr OUT.
REQ-006 Valid_In  input  1  Serial_In qualifier, from upstream lfsr Valid.
REQ-007 P_DATA  output  WIDTH  last completed parallel word, registered.
REQ-008 Data_Valid  output  1  one-cycle pulse, P_DATA holds a newly completed word.
REQ-009 Frame_Err  output  1  one-cycle pulse, partial word aborted on gap timeout.
REQ-010 Busy  output  1  high while a word is partially collected.

Function
REQ-011 States: IDLE and COLLECT; the block SHALL use no other states.
REQ-012 Bit sampling: a bit SHALL be taken on every rising edge where Valid_In=1; Serial_In is ignored when Valid_In=0.
REQ-013 Bit order: the first accepted bit SHALL land in P_DATA[0] and the WIDTH-th in P_DATA[WIDTH-1].
REQ-014 IDLE -> COLLECT on an accepted bit when WIDTH>1; bit counter = 1.
REQ-015 COLLECT: each accepted bit increments the bit counter and clears the gap counter.
REQ-016 Completion: on the edge accepting the WIDTH-th bit, P_DATA SHALL load the assembled word and Data_Valid SHALL be 1 for exactly the following cycle; state -> IDLE; bit counter -> 0.
REQ-017 Latency: one cycle from the last bit's sampling edge to Data_Valid/P_DATA visible.
REQ-018 Back-to-back: a bit accepted in the cycle Data_Valid is high SHALL be bit 0 of the next word, with no bubble required.
REQ-019 Gap: in COLLECT, each edge with Valid_In=0 increments the gap counter (saturating at GAP_MAX).
REQ-020 Abort: when the gap counter reaches GAP_MAX, Frame_Err SHALL pulse for one cycle, the partial word is discarded, counters clear, state -> IDLE.
REQ-021 P_DATA SHALL hold its previous value on abort and between words; it changes only on completion.
REQ-022 A gap shorter than GAP_MAX SHALL NOT corrupt or abort the word.
REQ-023 Data_Valid and Frame_Err SHALL never be high in the same cycle.
REQ-024 Busy = 1 exactly when state is COLLECT.
REQ-025 In IDLE, Valid_In=0 has no effect; the gap counter stays 0.

Reset
REQ-026 With RST=1 at a rising edge: state IDLE, bit and gap counters 0, P_DATA=0, Data_Valid=0, Frame_Err=0, Busy=0.
REQ-027 RST SHALL override all other inputs in the same edge.
REQ-028 Reset mid-word SHALL discard the partial word without a Frame_Err pulse.
REQ-029 The first bit accepted after RST deasserts SHALL be bit 0.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE, COLLECT) and the WIDTH/GAP_MAX defaults.
REQ-031 Counter widths SHALL be $clog2(WIDTH+1) for bits and $clog2(GAP_MAX+1) for gaps.
REQ-032 Single module; no sub-module is required. The shift register, counters and FSM reside in ser_collector.

Verification (WIDTH=8, GAP_MAX=3)
REQ-033 RST=1 for 2 cycles with random Serial_In/Valid_In -> P_DATA=0x00 and all flags 0.
REQ-034 0xA5 sent LSB-first with Valid_In continuously high -> Data_Valid pulses 1 cycle after the 8th edge, P_DATA=0xA5, Busy=0 in the pulse cycle.
REQ-035 0x3C sent with 2 invalid cycles between each bit -> P_DATA=0x3C, Frame_Err never asserted.
REQ-036 4 bits, then Valid_In=0 for 3 cycles -> Frame_Err pulses once and P_DATA stays 0x3C; a following 0x01 word completes correctly.
REQ-037 0xFF immediately followed by 0x00, no gap -> two Data_Valid pulses exactly 8 cycles apart, with P_DATA=0xFF then 0x00.
REQ-038 RST pulsed after 5 bits of a word, then 0x96 sent -> no Frame_Err, Busy drops during reset, P_DATA=0x96.
